modbus_uart_rx: RTL and testbench
=================================

Name: modbus_uart_rx

Overview:
Modbus RTU serial byte receiver placed directly upstream of the Modbus frame parser.
- Synchronises the raw RX line and oversamples it 16x with majority voting.
- Emits each received byte on data plus a one-cycle data_valid strobe; these drive the parser's datain/Enable inputs.
- Reports framing and parity errors and detects the RTU 3.5-character inter-frame silence (frame_end).

Parameters:
TICK_DIV, 27, clk cycles per oversample tick (50 MHz / (115200*16)); legal range 2..65535
T35_TICKS, 616, oversample ticks of idle line that mark end of frame (3.5 chars * 11 bits * 16)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
rx  in  1  raw serial line, idle high, asynchronous to clk
data  out  8  last received byte, LSB first on the wire
data_valid  out  1  one-cycle strobe, data valid in same cycle
frame_err  out  1  one-cycle strobe, stop bit sampled low
parity_err  out  1  one-cycle strobe, parity mismatch (0 unless MODBUS_RX_PARITY_EN)
frame_end  out  1  one-cycle strobe, T35_TICKS idle reached after at least one character
busy  out  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (async assert, sync release):
  - data=0; data_valid, frame_err, parity_err, frame_end, busy = 0.
  - Synchroniser flops = 1; state = IDLE.
  - Gap counter = T35_TICKS (saturated), so no frame_end after reset.
- Input path: 2-flop synchroniser, then a previous-value flop. Falling edge = prev 1, current 0.
- Tick generator: counter 0..TICK_DIV-1; tick pulses on wrap. Restarted at 0 on the start-edge cycle so bit sampling is phase-aligned.
- Sample counter s (0..15) increments per tick. Majority vote of samples s=7,8,9 is decided at s=9.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: falling edge -> START; busy=1; s=0; gap counter cleared.
  - START: at s=9, majority 1 -> IDLE (glitch rejected, no strobes); majority 0 -> continue. At s=15 -> DATA, bit index 0.
  - DATA: at s=9, shift majority into shift register LSB-first. At s=15, index++; after index 7 -> PARITY if the feature is enabled, else STOP.
  - PARITY: at s=9, capture the bit. At s=15 -> STOP.
  - STOP: at s=9, decide the stop bit, then -> IDLE the next cycle. Returning at mid-stop lets the next start edge be caught with no character loss.
    - Stop bit 1 and parity OK: data <= shift register and data_valid=1 in the following cycle.
    - Stop bit 0: frame_err=1; data_valid stays 0 and data is unchanged.
    - Parity mismatch with stop bit 1: parity_err=1; data_valid stays 0.
    - Stop bit 0 and parity mismatch together: both error strobes fire.
- Latency: data_valid rises one clk after the s=9 tick of the stop bit.
- Break / stuck-low line: after STOP returns to IDLE, no new start is accepted until the line has been seen high, because a falling edge is required.
- Gap counter:
  - Counts ticks only in IDLE with line high; saturates at T35_TICKS.
  - Any low sample in IDLE resets it to 0.
  - frame_end fires once on the transition to T35_TICKS, then stays silent until a new character is received.
- Reset mid-character: all state is discarded and no strobe is produced. The next complete character is received normally.
- Strobes are mutually exclusive in time with frame_end: frame_end can only occur in IDLE after the character completes.

Optional Feature:
MODBUS_RX_PARITY_EN
- Defined: frame is start, 8 data, even parity, stop (8E1, Modbus default). Parity mismatch behaves as described in STOP.
- Undefined: 8N1 receive (also accepts 8N2 senders). PARITY state is absent and parity_err is tied 0.

Decomposition:
- Package modbus_pkg holds:
  - FSM state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants OVERSAMPLE=16, MID_SAMPLE=8, default TICK_DIV and T35_TICKS.
- Sub-module modbus_baud_tick: TICK_DIV divider with synchronous restart input, producing the tick pulse. The FSM, voting and gap logic stay in the top module.

Test Plan:
- Exact baud, byte 0x02 (8E1 when enabled) -> exactly one data_valid with data=0x02; frame_err=0 and parity_err=0.
- Bytes 0x03, 0xA5, 0xFF, 0x00 back-to-back with the sender at +3% and then -3% baud -> four data_valid strobes with the correct values in order.
- rx low pulse of 4 ticks in IDLE -> no strobe; busy returns to 0 by the s=9 tick.
- Byte 0x55 with stop bit forced low -> frame_err single pulse, no data_valid, data unchanged. With the feature on, a flipped parity bit -> parity_err pulse only.
- 25-byte frame 0x02,0x03,0x14,... followed by idle -> 25 data_valid strobes, then frame_end exactly once, T35_TICKS ticks after the last stop mid-sample. No frame_end between bytes spaced 1 char apart.
- rst_n low during data bit 4 -> all outputs 0 immediately; after release, the next byte 0x3C is received cleanly and no frame_end occurs before any character.

Source files
------------

// File: rtl/modbus_pkg.sv
// Shared types and constants for the Modbus RTU serial receiver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package modbus_pkg;

  // Receiver character-level states
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int OVERSAMPLE    = 16;
  localparam int MID_SAMPLE    = 8;
  localparam int DEF_TICK_DIV  = 27;   // 50 MHz / (115200 * 16)
  localparam int DEF_T35_TICKS = 616;  // 3.5 chars * 11 bits * 16 ticks

  // Sample indices used for the three-sample vote and the bit boundary
  localparam logic [3:0] VOTE_LO     = 4'(MID_SAMPLE - 1);
  localparam logic [3:0] VOTE_MID    = 4'(MID_SAMPLE);
  localparam logic [3:0] VOTE_HI     = 4'(MID_SAMPLE + 1);
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  // Two-out-of-three majority
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/modbus_baud_tick.sv
// Oversample tick generator: one-cycle tick every TICK_DIV clocks, restartable.
// Latency: first tick TICK_DIV cycles after the restart cycle.
// Backpressure: none, free-running divider.
module modbus_baud_tick
  import modbus_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Tick on the wrap cycle so the pulse is exactly one clock wide
  assign tick_o = (cnt_q == LAST);

  // Next count: restart forces phase zero, otherwise count and wrap
  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (restart_i || (cnt_q == LAST)) begin
      cnt_d = '0;
    end
  end

  // Divider register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/modbus_uart_rx.sv
// Modbus RTU byte receiver: 16x oversampled UART with 3-sample vote and T3.5 frame-end detect.
// Latency: data_valid one clk after the mid-stop-bit tick; frame_end one clk after the T35_TICKS-th idle tick.
// Backpressure: none, all outputs are single-cycle strobes. Build option MODBUS_RX_PARITY_EN selects 8E1 (else 8N1).
module modbus_uart_rx
  import modbus_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int T35_TICKS = DEF_T35_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       frame_end,
  output logic       busy
);

  localparam int            GW      = $clog2(T35_TICKS + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(T35_TICKS);

  // Input path
  logic sync1_q, sync2_q, prev_q;
  logic fall_edge;

  // Timing
  logic tick;
  logic tick_restart;

  // Character FSM and datapath
  rx_state_e     state_q, state_d;
  logic [3:0]    samp_q, samp_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [1:0]    vote_q, vote_d;
  logic [7:0]    data_q, data_d;
  logic          dv_q, dv_d;
  logic          fe_q, fe_d;
  logic          fend_q, fend_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          armed_q, armed_d;
  logic          maj;
  logic          par_bad;

`ifdef MODBUS_RX_PARITY_EN
  logic par_q, par_d;
  logic pe_q, pe_d;

  // Even parity: the parity bit makes the count of ones across data+parity even
  assign par_bad    = par_q ^ (^shift_q);
  assign parity_err = pe_q;
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Two-flop synchroniser plus history flop for edge detection; idle line is high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign fall_edge    = prev_q & ~sync2_q;
  assign tick_restart = (state_q == IDLE) && fall_edge;

  modbus_baud_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_baud_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (tick_restart),
    .tick_o    (tick)
  );

  // The third vote sample is the live synchronised line at the deciding tick
  assign maj = maj3(vote_q[0], vote_q[1], sync2_q);

  // Next-state, sampling, gap counting and strobe generation
  always_comb begin
    state_d   = state_q;
    samp_d    = samp_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    vote_d    = vote_q;
    data_d    = data_q;
    dv_d      = 1'b0;
    fe_d      = 1'b0;
    fend_d    = 1'b0;
    gap_d     = gap_q;
    armed_d   = armed_q;
`ifdef MODBUS_RX_PARITY_EN
    par_d     = par_q;
    pe_d      = 1'b0;
`endif

    // Oversample position and the two early vote samples, in every active state
    if ((state_q != IDLE) && tick) begin
      samp_d = samp_q + 4'd1;
      if (samp_q == VOTE_LO)  vote_d[0] = sync2_q;
      if (samp_q == VOTE_MID) vote_d[1] = sync2_q;
    end

    unique case (state_q)
      IDLE: begin
        if (fall_edge) begin
          state_d = START;
          samp_d  = '0;
          gap_d   = '0;
        end else if (tick) begin
          if (!sync2_q) begin
            gap_d = '0;
          end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + GW'(1);
            // Fire once when silence first reaches T3.5 after a character
            if ((gap_q == GAP_MAX - GW'(1)) && armed_q) begin
              fend_d  = 1'b1;
              armed_d = 1'b0;
            end
          end
        end
      end

      START: begin
        if (tick) begin
          if ((samp_q == VOTE_HI) && maj) begin
            // Line back high at mid-start: a glitch, not a character
            state_d = IDLE;
          end else if (samp_q == LAST_SAMPLE) begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (samp_q == VOTE_HI) begin
            shift_d = {maj, shift_q[7:1]};
          end else if (samp_q == LAST_SAMPLE) begin
            bit_idx_d = bit_idx_q + 3'd1;
`ifdef MODBUS_RX_PARITY_EN
            if (bit_idx_q == 3'd7) state_d = PARITY;
`else
            if (bit_idx_q == 3'd7) state_d = STOP;
`endif
          end
        end
      end

`ifdef MODBUS_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (samp_q == VOTE_HI) begin
            par_d = maj;
          end else if (samp_q == LAST_SAMPLE) begin
            state_d = STOP;
          end
        end
      end
`endif

      STOP: begin
        // Decide at mid-stop and leave at once so a back-to-back start edge is not missed
        if (tick && (samp_q == VOTE_HI)) begin
          state_d = IDLE;
          armed_d = 1'b1;
          fe_d    = ~maj;
`ifdef MODBUS_RX_PARITY_EN
          pe_d    = par_bad;
`endif
          if (maj && !par_bad) begin
            data_d = shift_q;
            dv_d   = 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; gap starts saturated so reset alone never signals frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      samp_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      vote_q    <= 2'b11;
      data_q    <= '0;
      dv_q      <= 1'b0;
      fe_q      <= 1'b0;
      fend_q    <= 1'b0;
      gap_q     <= GAP_MAX;
      armed_q   <= 1'b0;
`ifdef MODBUS_RX_PARITY_EN
      par_q     <= 1'b0;
      pe_q      <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      samp_q    <= samp_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      vote_q    <= vote_d;
      data_q    <= data_d;
      dv_q      <= dv_d;
      fe_q      <= fe_d;
      fend_q    <= fend_d;
      gap_q     <= gap_d;
      armed_q   <= armed_d;
`ifdef MODBUS_RX_PARITY_EN
      par_q     <= par_d;
      pe_q      <= pe_d;
`endif
    end
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign frame_err  = fe_q;
  assign frame_end  = fend_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_modbus_uart_rx.sv
// Self-checking bench for modbus_uart_rx: serial line driven at nominal and skewed baud.
// Latency: n/a.
// Backpressure: n/a.
`timescale 1ns/1ps
module tb_modbus_uart_rx;

  localparam int TICK_DIV = 8;
  localparam int T35      = 616;
  localparam int BITC     = TICK_DIV * 16;   // clocks per bit at nominal baud
  localparam int FAST     = 124;             // sender +3%
  localparam int SLOW     = 132;             // sender -3%

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx    = 1'b1;
  logic [7:0] data;
  logic       data_valid, frame_err, parity_err, frame_end, busy;

  modbus_uart_rx #(
    .TICK_DIV  (TICK_DIV),
    .T35_TICKS (T35)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx         (rx),
    .data       (data),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .frame_end  (frame_end),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Observed strobes: kind 1 = byte, 2 = framing error, 3 = parity error
  typedef struct {
    int         kind;
    logic [7:0] dat;
  } ev_t;

  ev_t got_q[$];
  ev_t exp_q[$];
  int  fend_cnt = 0;
  int  fend_cyc = 0;
  int  dv_cyc   = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_valid) begin
        got_q.push_back('{kind: 1, dat: data});
        dv_cyc = cyc;
      end
      if (frame_err)  got_q.push_back('{kind: 2, dat: 8'h00});
      if (parity_err) got_q.push_back('{kind: 3, dat: 8'h00});
      if (frame_end) begin
        fend_cnt++;
        fend_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_c(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rx    = 1'b1;
    rst_n = 1'b0;
    wait_c(3);
    rst_n = 1'b1;
    wait_c(3);
  endtask

  // Drive one character: start, 8 data LSB first, [even parity], stop
  task automatic send_byte(input logic [7:0] b, input bit stop_v, input bit pflip, input int bc);
    rx = 1'b0;
    wait_c(bc);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_c(bc);
    end
`ifdef MODBUS_RX_PARITY_EN
    rx = (^b) ^ pflip;
    wait_c(bc);
`else
    if (pflip) rx = 1'b1;
`endif
    rx = stop_v;
    wait_c(bc);
    rx = 1'b1;
    if (!stop_v) wait_c(bc);
  endtask

  // Model: a good stop and parity yields the byte; otherwise the matching error strobes
  task automatic expect_char(input logic [7:0] b, input bit stop_v, input bit pflip);
    bit pbad;
`ifdef MODBUS_RX_PARITY_EN
    pbad = pflip;
`else
    pbad = 1'b0;
    if (pflip) pbad = 1'b0;
`endif
    if (stop_v && !pbad) exp_q.push_back('{kind: 1, dat: b});
    if (!stop_v)         exp_q.push_back('{kind: 2, dat: 8'h00});
    if (pbad)            exp_q.push_back('{kind: 3, dat: 8'h00});
  endtask

  task automatic compare_events(input string name, input int base);
    chk({name, " strobe count"}, 32'(got_q.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got_q.size()) begin
        chk($sformatf("%s ev%0d kind", name, i), 32'(got_q[base+i].kind), 32'(exp_q[i].kind));
        chk($sformatf("%s ev%0d data", name, i), 32'(got_q[base+i].dat),  32'(exp_q[i].dat));
      end
    end
    exp_q.delete();
  endtask

  typedef struct {
    logic [7:0] b;
    bit         stop_v;
    bit         pflip;
    int         bc;
    bit         e_dv;
    bit         e_fe;
    bit         e_pe;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] frame_bytes[25];

  initial begin
    int         base;
    int         fbase;
    int         last_dv;
    logic [7:0] last_good;

    // ---------------- reset state ----------------
    rst_n = 1'b0;
    rx    = 1'b1;
    wait_c(2);
    chk("reset data",       32'(data),       32'h0);
    chk("reset data_valid", 32'(data_valid), 32'h0);
    chk("reset frame_err",  32'(frame_err),  32'h0);
    chk("reset parity_err", 32'(parity_err), 32'h0);
    chk("reset frame_end",  32'(frame_end),  32'h0);
    chk("reset busy",       32'(busy),       32'h0);
    rst_n = 1'b1;
    wait_c(3);

    // ---------------- table: nominal, +3%, -3%, error cases ----------------
    tbl.push_back('{8'h02, 1'b1, 1'b0, BITC, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h03, 1'b1, 1'b0, FAST, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'hA5, 1'b1, 1'b0, FAST, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, FAST, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 1'b0, FAST, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h03, 1'b1, 1'b0, SLOW, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'hA5, 1'b1, 1'b0, SLOW, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'hFF, 1'b1, 1'b0, SLOW, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h00, 1'b1, 1'b0, SLOW, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{8'h55, 1'b0, 1'b0, BITC, 1'b0, 1'b1, 1'b0});
`ifdef MODBUS_RX_PARITY_EN
    tbl.push_back('{8'h5A, 1'b1, 1'b1, BITC, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{8'h11, 1'b0, 1'b1, BITC, 1'b0, 1'b1, 1'b1});
`endif

    base      = got_q.size();
    fbase     = fend_cnt;
    last_good = 8'h00;
    for (int i = 0; i < tbl.size(); i++) begin
      send_byte(tbl[i].b, tbl[i].stop_v, tbl[i].pflip, tbl[i].bc);
      if (tbl[i].e_dv) begin
        exp_q.push_back('{kind: 1, dat: tbl[i].b});
        last_good = tbl[i].b;
      end
      if (tbl[i].e_fe) exp_q.push_back('{kind: 2, dat: 8'h00});
      if (tbl[i].e_pe) exp_q.push_back('{kind: 3, dat: 8'h00});
    end
    wait_c(30);
    compare_events("table", base);
    chk("data held after error", 32'(data), 32'(last_good));
    chk("table no frame_end", 32'(fend_cnt - fbase), 32'h0);

    // ---------------- glitch rejection ----------------
    do_reset();
    base  = got_q.size();
    fbase = fend_cnt;
    rx = 1'b0;
    wait_c(4 * TICK_DIV);
    rx = 1'b1;
    chk("glitch busy high", 32'(busy), 32'h1);
    wait_c(7 * TICK_DIV);
    chk("glitch busy cleared", 32'(busy), 32'h0);
    wait_c(T35 * TICK_DIV + 200);
    compare_events("glitch", base);
    chk("glitch no frame_end", 32'(fend_cnt - fbase), 32'h0);

    // ---------------- 25-byte frame, random payload, then T3.5 silence ----------------
    do_reset();
    base  = got_q.size();
    fbase = fend_cnt;
    frame_bytes[0] = 8'h02;
    frame_bytes[1] = 8'h03;
    frame_bytes[2] = 8'h14;
    for (int i = 3; i < 25; i++) frame_bytes[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 25; i++) begin
      send_byte(frame_bytes[i], 1'b1, 1'b0, BITC);
      expect_char(frame_bytes[i], 1'b1, 1'b0);
      if (i == 7 || i == 15) wait_c(10 * BITC);
    end
    chk("frame no early frame_end", 32'(fend_cnt - fbase), 32'h0);
    last_dv = dv_cyc;
    wait_c(T35 * TICK_DIV + 400);
    chk("frame_end count", 32'(fend_cnt - fbase), 32'h1);
    if (fend_cnt - fbase == 1)
      chk("frame_end delay", 32'(fend_cyc - last_dv), 32'(T35 * TICK_DIV));
    compare_events("frame", base);

    // ---------------- reset during data bit 4 ----------------
    do_reset();
    base  = got_q.size();
    fbase = fend_cnt;
    rx = 1'b0;
    wait_c(BITC);
    for (int i = 0; i < 4; i++) begin
      rx = (i == 2 || i == 3) ? 1'b1 : 1'b0;   // 0x3C bits 0..3
      wait_c(BITC);
    end
    rx = 1'b1;                                 // bit 4 of 0x3C
    wait_c(BITC / 2);
    chk("mid-char busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid reset data",       32'(data),       32'h0);
    chk("mid reset data_valid", 32'(data_valid), 32'h0);
    chk("mid reset frame_err",  32'(frame_err),  32'h0);
    chk("mid reset parity_err", 32'(parity_err), 32'h0);
    chk("mid reset frame_end",  32'(frame_end),  32'h0);
    chk("mid reset busy",       32'(busy),       32'h0);
    wait_c(3);
    rst_n = 1'b1;
    wait_c(300);
    chk("no frame_end before char", 32'(fend_cnt - fbase), 32'h0);
    send_byte(8'h3C, 1'b1, 1'b0, BITC);
    expect_char(8'h3C, 1'b1, 1'b0);
    wait_c(30);
    compare_events("post reset", base);
    chk("post reset data", 32'(data), 32'h3C);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
